alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU (`alu`, 5-bit `alu_control`). It accepts operation requests from two independent masters, such as the display/touch input path and a test pattern engine, over valid/ready handshakes. Requests are granted round-robin. The arbiter drives registered operands into the ALU, captures the result one cycle later, and returns it to the granted requester over a valid/ready response channel. It sits between the requesters and the single `alu` instance, replacing the direct register drive of `alu_control`/`alu_src1`/`alu_src2`.

## Interface
- DATA_W, 32, operand/result width (only 32 is supported by `alu`)
- CTRL_W, 5, ALU control width
- clk  in  1  system clock (10 MHz board clock)
- resetn  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_control / req1_control  in  CTRL_W  ALU operation
- req0_src1, req0_src2 / req1_src1, req1_src2  in  DATA_W  operands
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_result  out  DATA_W  result, shared by both response channels, qualified by rspN_valid
- alu_control  out  CTRL_W  registered, to `alu`
- alu_src1, alu_src2  out  DATA_W  registered, to `alu`
- alu_result  in  DATA_W  from `alu`
- busy  out  1  state != IDLE

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - The grant is computed combinationally from the valids and the `last` pointer.
  - With a single valid, that requester wins.
  - With both valid, the requester not equal to `last` wins.
  - `reqN_ready` = (state==IDLE) & grant==N. Readys are never asserted together.
  - On handshake: load `alu_control`/`alu_src1`/`alu_src2` from the winner, store `owner`=N, go to EXEC.
- **EXEC:** register `alu_result` into `rsp_result`, then go to RESP.
- **RESP:**
  - `rsp{owner}_valid`=1. The other `rsp_valid` stays 0.
  - On `rsp{owner}_ready`: set `last`=owner and go to IDLE.
  - Otherwise hold the state, `rsp_result` and valid stable.
- ALU operand registers hold their values until the next grant. `rsp_result` holds until the next EXEC.
- A requester may deassert valid before it is granted. No grant occurs and no state changes.
- A response-channel ready asserted for the non-owner is ignored.

## Timing
- Reset values:
  - `reqN_ready`=0, `rspN_valid`=0, `busy`=0
  - `alu_control`=0, `alu_src1`=0, `alu_src2`=0, `rsp_result`=0
  - `last`=1, so req0 wins the first tie.
- Latency:
  - Accept at edge T.
  - EXEC during T+1.
  - `rspN_valid` is high from T+2.
- Peak throughput is one op per 3 cycles, when `rsp_ready` is held high.
- Next accept earliest: the cycle after the response handshake. There is no bypass from RESP to accept.
- `alu_result` is sampled exactly one cycle after operands are registered. `alu` must settle within one clk period.
- Reset asserted mid-operation:
  - Immediate return to IDLE, all outputs forced to their reset values.
  - The in-flight result is discarded and no response is issued.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - Adds ports `stat0_count`, `stat1_count`  out  16.
  - Each counter increments by 1 on its requester's response handshake and wraps 0xFFFF→0.
  - Counters reset to 0.
- `ALU_ARB_STATS_EN` undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Bench ALU model: result = src1 ^ src2 (control ignored).
- Reset → all outputs 0, busy=0.
- Single request: req0 {ctrl 5'd3, 0x0000_00F0, 0x0000_0F0F}, rsp0_ready=1. Expected:
  - req0_ready high in the accept cycle.
  - rsp0_valid 2 cycles later with rsp_result=0x0000_0FFF.
  - rsp1_valid stays 0.
- Tie and round-robin: req0 and req1 held valid continuously with rsp ready high. Expected:
  - Grants alternate req0, req1, req0, req1.
  - Accepts are 3 cycles apart.
- Backpressure: rsp1_ready=0 for 5 cycles while rsp1_valid=1. Expected:
  - rsp_result and valid stable.
  - req0 not accepted until 1 cycle after rsp1_ready rises.
- Reset mid-op: assert resetn=0 during EXEC. Expected:
  - No rsp_valid.
  - busy=0 immediately.
  - After release, req0 wins the first tie.
- With `ALU_ARB_STATS_EN`:
  - 3 req0 ops and 2 req1 ops → stat0_count=3, stat1_count=2.
  - Force stat0_count to 0xFFFF, complete one req0 op → 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer placing two requesters
// onto one shared combinational ALU. Each accepted operation registers its
// operands into the ALU, captures the result one cycle later, and returns it
// on the owner's response channel.
// Optional feature macro: ALU_ARB_STATS_EN adds per-requester 16-bit
// completed-operation counters (stat0_count, stat1_count).

module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_control,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_control,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       stat0_count,
  output logic [15:0]       stat1_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last;
  logic   grant;
  logic   any_valid;
  logic   accept;
  logic   rsp_done;

  // Pick the winner: a lone requester wins, a tie goes to whoever did not finish last
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && any_valid && !grant;
  assign req1_ready = (state == IDLE) && any_valid && grant;
  assign accept     = req0_ready | req1_ready;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign busy = (state != IDLE);

  // Sequencer: accept -> drive ALU operands, sample result, hold it until the owner takes it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      alu_control <= '0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      rsp_result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner       <= grant;
            alu_control <= grant ? req1_control : req0_control;
            alu_src1    <= grant ? req1_src1 : req0_src1;
            alu_src2    <= grant ? req1_src2 : req0_src2;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Count completed responses per requester; counters wrap naturally at 16 bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat0_count <= '0;
      stat1_count <= '0;
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        stat0_count <= stat0_count + 16'd1;
      end
      if (rsp1_valid && rsp1_ready) begin
        stat1_count <= stat1_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with an XOR ALU model and a transaction-level
// reference model (round-robin winner, accept-to-response timeline, result).
// Optional feature macro: ALU_ARB_STATS_EN enables the counter scenario.

module tb_alu_arbiter;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 5;

  logic              clk;
  logic              resetn;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [CTRL_W-1:0] req0_control, req1_control;
  logic [DATA_W-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_src1, alu_src2, alu_result;
  logic              busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]       stat0_count, stat1_count;
`endif

  alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stat0_count(stat0_count), .stat1_count(stat1_count)
`endif
  );

  // Shared ALU stand-in: control is ignored, result is the XOR of the operands
  assign alu_result = alu_src1 ^ alu_src2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level reference model
  bit                m_busy;
  int                m_acc;
  bit                m_owner;
  bit                m_last;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_s1, m_s2, m_rsp;
  int                m_cnt0, m_cnt1;
  bit                e_r0, e_r1, e_v0, e_v1;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_owner = 0; m_last = 1;
    m_ctrl = '0; m_s1 = '0; m_s2 = '0; m_rsp = '0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Expected handshake outputs for the current cycle's inputs
  task automatic model_eval();
    e_r0 = 0; e_r1 = 0;
    if (!m_busy && resetn) begin
      if (req0_valid && req1_valid) begin
        if (m_last) e_r0 = 1; else e_r1 = 1;
      end else if (req0_valid) e_r0 = 1;
      else if (req1_valid) e_r1 = 1;
    end
    e_v0 = m_busy && (cyc >= m_acc + 2) && !m_owner;
    e_v1 = m_busy && (cyc >= m_acc + 2) && m_owner;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  // Update the model with this cycle's transfers, then cross the active edge
  task automatic advance();
    if (!resetn) begin
      model_reset();
    end else begin
      if (e_r0 || e_r1) begin
        m_busy  = 1;
        m_acc   = cyc;
        m_owner = e_r1;
        m_ctrl  = e_r1 ? req1_control : req0_control;
        m_s1    = e_r1 ? req1_src1 : req0_src1;
        m_s2    = e_r1 ? req1_src2 : req0_src2;
      end
      if (m_busy && cyc == m_acc + 1) m_rsp = m_s1 ^ m_s2;
      if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
        m_busy = 0;
        m_last = m_owner;
        if (m_owner) m_cnt1++; else m_cnt0++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) begin
      settle();
      advance();
    end
  endtask

  task automatic test_reset();
    settle();
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b required 00000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
    end
    checks++;
    if (alu_control !== '0 || alu_src1 !== '0 || alu_src2 !== '0 || rsp_result !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got ctrl %h s1 %h s2 %h res %h required all 0",
               alu_control, alu_src1, alu_src2, rsp_result);
    end
    advance();
    resetn = 1'b1;
  endtask

  task automatic test_single();
    req0_valid = 1; req0_control = 5'd3; req0_src1 = 32'h0000_00F0; req0_src2 = 32'h0000_0F0F;
    rsp0_ready = 1; rsp1_ready = 1;
    settle();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_accept got r0 %b r1 %b required 1 0", req0_ready, req1_ready);
    end
    advance();
    req0_valid = 0;
    settle();
    checks++;
    if (busy !== 1'b1 || rsp0_valid !== 1'b0 || alu_src1 !== 32'h0000_00F0 ||
        alu_src2 !== 32'h0000_0F0F || alu_control !== 5'd3) begin
      errors++;
      $display("[TB] FAIL single_exec got busy %b v0 %b ctrl %h s1 %h s2 %h",
               busy, rsp0_valid, alu_control, alu_src1, alu_src2);
    end
    advance();
    settle();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'h0000_0FFF) begin
      errors++;
      $display("[TB] FAIL single_resp got v0 %b v1 %b res %h required 1 0 00000fff",
               rsp0_valid, rsp1_valid, rsp_result);
    end
    advance();
    settle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle got busy %b required 0", busy);
    end
    advance();
  endtask

  task automatic test_round_robin();
    int prev_acc = -1;
    int prev_g = -1;
    int g;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 12; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_control = 5'($urandom); req0_src1 = $urandom; req0_src2 = $urandom;
      req1_control = 5'($urandom); req1_src1 = $urandom; req1_src2 = $urandom;
      settle();
      checks++;
      if (req0_ready !== e_r0 || req1_ready !== e_r1) begin
        errors++;
        $display("[TB] FAIL rr_grant cyc %0d got %b%b required %b%b",
                 cyc, req0_ready, req1_ready, e_r0, e_r1);
      end
      if (req0_ready || req1_ready) begin
        g = req1_ready ? 1 : 0;
        if (prev_acc >= 0) begin
          checks++;
          if (cyc - prev_acc != 3) begin
            errors++;
            $display("[TB] FAIL rr_spacing got %0d cycles required 3", cyc - prev_acc);
          end
          checks++;
          if (g == prev_g) begin
            errors++;
            $display("[TB] FAIL rr_alternate got req%0d twice required alternation", g);
          end
        end
        prev_acc = cyc;
        prev_g = g;
      end
      if (e_v0 || e_v1) begin
        checks++;
        if (rsp_result !== m_rsp || rsp0_valid !== e_v0 || rsp1_valid !== e_v1) begin
          errors++;
          $display("[TB] FAIL rr_result got %h v %b%b required %h v %b%b",
                   rsp_result, rsp0_valid, rsp1_valid, m_rsp, e_v0, e_v1);
        end
      end
      advance();
    end
    req0_valid = 0; req1_valid = 0;
    drain(4);
  endtask

  task automatic test_back_to_back_backpressure();
    logic [DATA_W-1:0] held;
    rsp0_ready = 0; rsp1_ready = 0;
    req1_valid = 1; req1_control = 5'd7; req1_src1 = 32'hDEAD_BEEF; req1_src2 = 32'h1234_5678;
    held = 32'hDEAD_BEEF ^ 32'h1234_5678;
    settle();
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_accept got r1 %b required 1", req1_ready);
    end
    advance();
    req1_valid = 0;
    settle();
    advance();
    req0_valid = 1; req0_control = 5'd1; req0_src1 = 32'h5555_0000; req0_src2 = 32'h0000_AAAA;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== held || req0_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold got v1 %b v0 %b res %h r0 %b required 1 0 %h 0",
                 rsp1_valid, rsp0_valid, rsp_result, req0_ready, held);
      end
      advance();
    end
    rsp1_ready = 1;
    settle();
    checks++;
    if (rsp1_valid !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release got v1 %b r0 %b required 1 0", rsp1_valid, req0_ready);
    end
    advance();
    rsp1_ready = 0; rsp0_ready = 1;
    settle();
    checks++;
    if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_next_accept got r0 %b v1 %b required 1 0", req0_ready, rsp1_valid);
    end
    advance();
    req0_valid = 0;
    drain(3);
  endtask

  task automatic test_reset_mid_op();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_src1 = 32'h1; req0_src2 = 32'h2;
    settle();
    advance();
    req0_valid = 0;
    drain(3);
    req1_valid = 1; req1_src1 = 32'hF0F0_F0F0; req1_src2 = 32'h0;
    settle();
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre_accept got r1 %b required 1", req1_ready);
    end
    advance();
    req1_valid = 0;
    settle();
    resetn = 1'b0;
    #1;
    model_reset();
    model_eval();
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
        alu_src1 !== '0 || rsp_result !== '0) begin
      errors++;
      $display("[TB] FAIL rst_immediate got busy %b v %b%b s1 %h res %h required all 0",
               busy, rsp0_valid, rsp1_valid, alu_src1, rsp_result);
    end
    advance();
    resetn = 1'b1;
    req0_valid = 1; req1_valid = 1;
    settle();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_first_tie got r0 %b r1 %b required 1 0", req0_ready, req1_ready);
    end
    advance();
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (rsp1_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_no_stale_rsp got v1 %b required 0", rsp1_valid);
      end
      advance();
    end
  endtask

  task automatic test_random(int n);
    for (int i = 0; i < n; i++) begin
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_control = 5'($urandom); req0_src1 = $urandom; req0_src2 = $urandom;
      req1_control = 5'($urandom); req1_src1 = $urandom; req1_src2 = $urandom;
      rsp0_ready = ($urandom_range(0, 3) != 0); rsp1_ready = ($urandom_range(0, 3) != 0);
      settle();
      checks++;
      if (req0_ready !== e_r0 || req1_ready !== e_r1) begin
        errors++;
        $display("[TB] FAIL rand_ready cyc %0d got %b%b required %b%b",
                 cyc, req0_ready, req1_ready, e_r0, e_r1);
      end
      checks++;
      if (rsp0_valid !== e_v0 || rsp1_valid !== e_v1 || busy !== m_busy) begin
        errors++;
        $display("[TB] FAIL rand_valid cyc %0d got v %b%b busy %b required v %b%b busy %b",
                 cyc, rsp0_valid, rsp1_valid, busy, e_v0, e_v1, m_busy);
      end
      checks++;
      if (alu_control !== m_ctrl || alu_src1 !== m_s1 || alu_src2 !== m_s2) begin
        errors++;
        $display("[TB] FAIL rand_operands cyc %0d got %h %h %h required %h %h %h",
                 cyc, alu_control, alu_src1, alu_src2, m_ctrl, m_s1, m_s2);
      end
      checks++;
      if (rsp_result !== m_rsp) begin
        errors++;
        $display("[TB] FAIL rand_result cyc %0d got %h required %h", cyc, rsp_result, m_rsp);
      end
      advance();
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    drain(4);
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    settle();
    resetn = 1'b0;
    #1;
    model_reset();
    advance();
    resetn = 1'b1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 5; k++) begin
      req0_valid = (k < 3); req1_valid = (k >= 3);
      settle();
      advance();
      req0_valid = 0; req1_valid = 0;
      drain(3);
    end
    checks++;
    if (stat0_count !== 16'd3 || stat1_count !== 16'd2 || m_cnt0 != 3 || m_cnt1 != 2) begin
      errors++;
      $display("[TB] FAIL stats_count got %0d %0d required 3 2", stat0_count, stat1_count);
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_control = '0; req1_control = '0;
    req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_backpressure();
    test_reset_mid_op();
    test_random(400);
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
